// File: rtl/keycode_rx.sv
// keycode_rx: receive side of the keypad encoder interface.
//
// Detects key presses (strobe rising edge, or a code change while held) and checks
// that each code is in 0..19. It queues valid presses in a DEPTH-entry FIFO and
// presents the head over a valid/ready handshake, both as binary and as a one-hot.
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat of a held key. The
// first repeat comes after REPEAT_DELAY cycles, then one every REPEAT_RATE cycles.
//
// Ports:
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   code_i        key code from encoder, meaningful only while strobe_i=1
//   strobe_i      key-present level strobe
//   key_valid_o   FIFO head valid
//   key_ready_i   consumer accepts head when key_valid_o & key_ready_i
//   key_code_o    head entry, binary 0..19 (0 when empty)
//   key_onehot_o  head entry decoded, 1 << key_code_o (0 when empty)
//   count_o       entries held, 0..DEPTH
//   overflow_o    1-cycle pulse: valid press dropped because FIFO full
//   bad_code_o    1-cycle pulse: press with code >= 20 discarded
module keycode_rx #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned REPEAT_DELAY = 1000,
    parameter int unsigned REPEAT_RATE  = 250
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [4:0]               code_i,
    input  logic                     strobe_i,
    output logic                     key_valid_o,
    input  logic                     key_ready_i,
    output logic [4:0]               key_code_o,
    output logic [19:0]              key_onehot_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     bad_code_o
);

    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = $clog2(DEPTH) + 1;
    localparam logic [4:0]  MaxCode = 5'd19;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keycode_rx: DEPTH must be a power of 2 and >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keycode_rx: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

`ifdef KEY_REPEAT_EN
    typedef enum logic [1:0] {StIdle, StPressed, StRepeating} state_e;
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] DelayEnd = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RateEnd  = RptW'(REPEAT_RATE - 1);
    logic [RptW-1:0] rpt_cnt_q;
`else
    typedef enum logic {StIdle, StPressed} state_e;
`endif

    state_e     state_q;
    logic       strobe_q;
    logic [4:0] last_code_q;
    logic       bad_code_q;

    logic       code_ok;
    logic       key_event;
    logic       rpt_push;
    logic       push_req;
    logic [4:0] push_code;

    assign code_ok = (code_i <= MaxCode);

    // state_q != StIdle always coincides with strobe_q=1; both gate the change detector.
    assign key_event = strobe_i &
                       (~strobe_q | ((state_q != StIdle) & (code_i != last_code_q)));

`ifdef KEY_REPEAT_EN
    // A repeat needs the same key still held; a code change in this cycle takes priority.
    assign rpt_push = strobe_i & ~key_event & (last_code_q <= MaxCode) &
                      (((state_q == StPressed) & (rpt_cnt_q == DelayEnd)) |
                       ((state_q == StRepeating) & (rpt_cnt_q == RateEnd)));
`else
    assign rpt_push = 1'b0;
`endif

    assign push_req  = (key_event & code_ok) | rpt_push;
    assign push_code = key_event ? code_i : last_code_q;

    // Press detection FSM and repeat timer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            strobe_q    <= 1'b0;
            last_code_q <= 5'd0;
            bad_code_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q   <= '0;
`endif
        end else begin
            strobe_q   <= strobe_i;
            bad_code_q <= key_event & ~code_ok;
            if (key_event) begin
                last_code_q <= code_i;
            end
            if (!strobe_i) begin
                state_q <= StIdle;
`ifdef KEY_REPEAT_EN
                rpt_cnt_q <= '0;
`endif
            end else if (key_event) begin
                state_q <= StPressed;
`ifdef KEY_REPEAT_EN
                rpt_cnt_q <= '0;
            end else if (state_q == StPressed) begin
                if (rpt_cnt_q == DelayEnd) begin
                    state_q   <= StRepeating;
                    rpt_cnt_q <= '0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + RptW'(1);
                end
            end else if (state_q == StRepeating) begin
                if (rpt_cnt_q == RateEnd) begin
                    rpt_cnt_q <= '0;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + RptW'(1);
                end
`endif
            end
        end
    end

    // FIFO
    logic [4:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            overflow_q;
    logic            full;
    logic            pop;
    logic            push_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign pop     = (count_q != '0) & key_ready_i;
    // While full, a same-cycle pop frees the slot being written.
    assign push_ok = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 5'd0;
            end
        end else begin
            count_q    <= count_d;
            overflow_q <= push_req & full & ~pop;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign key_valid_o  = (count_q != '0);
    assign key_code_o   = key_valid_o ? mem_q[rd_ptr_q] : 5'd0;
    assign key_onehot_o = key_valid_o ? (20'd1 << key_code_o) : 20'd0;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign bad_code_o   = bad_code_q;

endmodule

// File: tb/tb_keycode_rx.sv
// Self-checking bench for keycode_rx: directed vector table, a held-key repeat
// sequence, and randomized traffic compared against a queue-based reference model.
module tb_keycode_rx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned RD    = 10;
    localparam int unsigned RR    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  code = 5'd0;
    logic        strobe = 1'b0;
    logic        key_ready = 1'b0;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [19:0] key_onehot;
    logic [2:0]  count;
    logic        overflow;
    logic        bad_code;

    always #5 clk = ~clk;

    keycode_rx #(
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .code_i       (code),
        .strobe_i     (strobe),
        .key_valid_o  (key_valid),
        .key_ready_i  (key_ready),
        .key_code_o   (key_code),
        .key_onehot_o (key_onehot),
        .count_o      (count),
        .overflow_o   (overflow),
        .bad_code_o   (bad_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of pending codes plus press bookkeeping.
    int q[$];
    bit m_prev  = 1'b0;
    int m_last  = 0;
    bit m_ovf   = 1'b0;
    bit m_bad   = 1'b0;
    int m_start = 0;
    int m_t     = 0;

    task automatic model_step();
        bit pop;
        bit ev;
        bit push;
        int val;
        int d;
        if (rst) begin
            q.delete();
            m_prev = 1'b0;
            m_last = 0;
            m_ovf  = 1'b0;
            m_bad  = 1'b0;
        end else begin
            pop   = (q.size() > 0) && key_ready;
            ev    = strobe && (!m_prev || int'(code) != m_last);
            push  = 1'b0;
            val   = 0;
            m_bad = 1'b0;
            if (ev) begin
                m_last  = int'(code);
                m_start = m_t;
                if (code < 20) begin
                    push = 1'b1;
                    val  = int'(code);
                end else begin
                    m_bad = 1'b1;
                end
            end
`ifdef KEY_REPEAT_EN
            else if (strobe && m_last < 20) begin
                d = m_t - m_start;
                if (d == int'(RD) || (d > int'(RD) && (d - int'(RD)) % int'(RR) == 0)) begin
                    push = 1'b1;
                    val  = m_last;
                end
            end
`endif
            m_ovf = push && q.size() == int'(DEPTH) && !pop;
            if (pop) void'(q.pop_front());
            if (push && !m_ovf) q.push_back(val);
            m_prev = strobe;
        end
        m_t++;
    endtask

    task automatic check_model();
        logic [4:0]  ec;
        logic [19:0] eo;
        ec = (q.size() > 0) ? 5'(q[0]) : 5'd0;
        eo = (q.size() > 0) ? (20'd1 << ec) : 20'd0;
        chk("mdl_valid", {31'd0, key_valid}, {31'd0, q.size() > 0});
        chk("mdl_code", {27'd0, key_code}, {27'd0, ec});
        chk("mdl_onehot", {12'd0, key_onehot}, {12'd0, eo});
        chk("mdl_count", {29'd0, count}, 32'(q.size()));
        chk("mdl_overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("mdl_bad_code", {31'd0, bad_code}, {31'd0, m_bad});
    endtask

    // Apply inputs, clock once, update the model, then sample 1 time unit after the edge.
    task automatic tick(input logic r, input logic s, input logic [4:0] c, input logic rdy);
        rst       = r;
        strobe    = s;
        code      = c;
        key_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic [4:0] c;
        logic       rdy;
        logic       ev;
        logic [4:0] ec;
        int         ecnt;
        logic       eo;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [4:0] c, input logic rdy,
                       input logic ev, input logic [4:0] ec, input int ecnt,
                       input logic eo, input logic eb);
        vec_t v;
        v = '{r: r, s: s, c: c, rdy: rdy, ev: ev, ec: ec, ecnt: ecnt, eo: eo, eb: eb};
        tbl.push_back(v);
    endtask

    int got[$];
    int expv[$];

    initial begin
        // Reset held with key down, then one entry of 7
        add(1, 1,  7, 0,  0,  0, 0, 0, 0);
        add(1, 1,  7, 0,  0,  0, 0, 0, 0);
        add(0, 1,  7, 0,  1,  7, 1, 0, 0);
        add(0, 1,  7, 1,  0,  0, 0, 0, 0);
        add(0, 0,  7, 0,  0,  0, 0, 0, 0);
        // Single press, head stable while not ready
        add(0, 1,  5, 0,  1,  5, 1, 0, 0);
        add(0, 1,  5, 0,  1,  5, 1, 0, 0);
        add(0, 0,  5, 0,  1,  5, 1, 0, 0);
        add(0, 0,  5, 1,  0,  0, 0, 0, 0);
        // Code-change presses fill the FIFO; fifth one overflows
        add(0, 1,  1, 0,  1,  1, 1, 0, 0);
        add(0, 1,  2, 0,  1,  1, 2, 0, 0);
        add(0, 1,  3, 0,  1,  1, 3, 0, 0);
        add(0, 1,  4, 0,  1,  1, 4, 0, 0);
        add(0, 1,  9, 0,  1,  1, 4, 1, 0);
        add(0, 1,  9, 0,  1,  1, 4, 0, 0);
        // Full with pop and push of 12 in the same cycle
        add(0, 1, 12, 1,  1,  2, 4, 0, 0);
        add(0, 0, 12, 1,  1,  3, 3, 0, 0);
        add(0, 0, 12, 1,  1,  4, 2, 0, 0);
        add(0, 0, 12, 1,  1, 12, 1, 0, 0);
        add(0, 0, 12, 1,  0,  0, 0, 0, 0);
        // Bad codes and the 19/20 boundary
        add(0, 1, 22, 0,  0,  0, 0, 0, 1);
        add(0, 1, 22, 0,  0,  0, 0, 0, 0);
        add(0, 0, 22, 0,  0,  0, 0, 0, 0);
        add(0, 1, 19, 0,  1, 19, 1, 0, 0);
        add(0, 0, 19, 1,  0,  0, 0, 0, 0);
        add(0, 1, 20, 0,  0,  0, 0, 0, 1);
        add(0, 1,  0, 0,  1,  0, 1, 0, 0);
        add(0, 0,  0, 1,  0,  0, 0, 0, 0);
        // Reset mid-operation with key held
        add(0, 1,  6, 0,  1,  6, 1, 0, 0);
        add(1, 1,  6, 0,  0,  0, 0, 0, 0);
        add(0, 1,  6, 0,  1,  6, 1, 0, 0);
        add(0, 0,  6, 1,  0,  0, 0, 0, 0);

        @(negedge clk);
        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), {31'd0, key_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_code", i), {27'd0, key_code}, {27'd0, tbl[i].ec});
            chk($sformatf("tbl%0d_onehot", i), {12'd0, key_onehot},
                {12'd0, tbl[i].ev ? (20'd1 << tbl[i].ec) : 20'd0});
            chk($sformatf("tbl%0d_count", i), {29'd0, count}, 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].eo});
            chk($sformatf("tbl%0d_bad", i), {31'd0, bad_code}, {31'd0, tbl[i].eb});
        end

        // Held key with code 3 for 30 cycles, consumer always ready
        tick(1, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            tick(0, i < 30, 5'd3, 1);
            if (key_valid) got.push_back(i + 1);
        end
`ifdef KEY_REPEAT_EN
        expv = '{1, 11, 15, 19, 23, 27};
`else
        expv = '{1};
`endif
        chk("hold_entries", 32'(got.size()), 32'(expv.size()));
        for (int i = 0; i < expv.size() && i < got.size(); i++) begin
            chk($sformatf("hold_entry%0d_cycle", i), 32'(got[i]), 32'(expv[i]));
        end

        // Randomized traffic against the model
        begin
            logic       s_cur;
            logic [4:0] c_cur;
            int         hold_left;
            logic       rdy;
            s_cur     = 1'b0;
            c_cur     = 5'd0;
            hold_left = 0;
            tick(1, 0, 0, 0);
            for (int n = 0; n < 3000; n++) begin
                if (hold_left == 0) begin
                    s_cur     = ~s_cur;
                    hold_left = s_cur ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 5));
                    if (s_cur) c_cur = 5'($urandom_range(0, 23));
                end else if (s_cur && $urandom_range(0, 15) == 0) begin
                    c_cur = 5'($urandom_range(0, 23));
                end
                hold_left--;
                rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 3) != 0);
                tick($urandom_range(0, 499) == 0, s_cur,
                     s_cur ? c_cur : 5'($urandom_range(0, 31)), rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
